// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction-fetch stage:
//   - fetch_state_e : fetch FSM states (BOOT, RUN, HALTED)
//   - if_entry_t    : contents of the IF/ID register (pc, instr, fault)
//   - default RESET_PC, NOP and EBREAK encodings
// ---------------------------------------------------------------------------
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEF    = 32'h0000_0000;
    localparam logic [31:0] EBREAK_WORD_DEF = 32'h0010_0073;
    localparam logic [31:0] NOP_WORD_DEF    = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
    } if_entry_t;

endpackage

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
// Instruction-fetch stage. Holds the PC, addresses a combinational
// instruction memory and captures the returned word into the IF/ID
// register offered to decode.
//
// Ports:
//   clk            in   clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   iaddr          out  byte address to instruction memory (== pc)
//   idata          in   instruction word at iaddr, same cycle
//   redirect_valid in   load redirect_pc this cycle (highest priority)
//   redirect_pc    in   redirect target
//   out_valid      out  IF/ID register holds an entry
//   out_ready      in   decode accepts the entry this cycle
//   out_pc         out  PC of the held entry
//   out_instr      out  instruction word of the held entry
//   out_fault      out  held entry is a misaligned-target fault
//   halted         out  FSM is in HALTED
//   dbg_state      out  raw FSM state, for observation only
//
// Handshake: an entry moves to decode on every rising edge where
// out_valid && out_ready. While out_valid && !out_ready, out_pc,
// out_instr and out_fault hold. A redirect in the same cycle still
// counts as a completed handshake for decode, but the register is then
// flushed or replaced by the redirect result.
// ---------------------------------------------------------------------------
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = RESET_PC_DEF,
    parameter logic [31:0] EBREAK_WORD = EBREAK_WORD_DEF,
    parameter logic [31:0] NOP_WORD    = NOP_WORD_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] iaddr,
    input  logic [31:0] idata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output logic        out_fault,
    output logic        halted,
    output logic [1:0]  dbg_state
);

    fetch_state_e r_state;
    fetch_state_e w_state_nxt;

    logic [31:0]  r_pc;
    logic         r_valid;
    if_entry_t    r_entry;

    logic         w_slot_free;
    logic         w_capture;
    logic         w_is_ebreak;
    logic         w_redir_aligned;
    logic         w_redir_misaligned;

    assign w_slot_free        = !r_valid || out_ready;
    assign w_is_ebreak        = (idata == EBREAK_WORD);
    assign w_redir_aligned    = redirect_valid && (redirect_pc[1:0] == 2'b00);
    assign w_redir_misaligned = redirect_valid && (redirect_pc[1:0] != 2'b00);
    // A redirect pre-empts any capture in the same cycle.
    assign w_capture          = (r_state == ST_RUN) && w_slot_free && !redirect_valid;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        if (w_redir_aligned) begin
            w_state_nxt = ST_RUN;
        end else if (w_redir_misaligned) begin
            w_state_nxt = ST_HALTED;
        end else begin
            case (r_state)
                ST_BOOT:   w_state_nxt = ST_RUN;
                ST_RUN:    if (w_capture && w_is_ebreak) w_state_nxt = ST_HALTED;
                ST_HALTED: w_state_nxt = ST_HALTED;
                default:   w_state_nxt = ST_BOOT;
            endcase
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        halted    = (r_state == ST_HALTED);
        dbg_state = r_state;
    end

    // ---------------- PC and IF/ID register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc          <= RESET_PC;
            r_valid       <= 1'b0;
            r_entry.pc    <= 32'h0;
            r_entry.instr <= NOP_WORD;
            r_entry.fault <= 1'b0;
        end else if (w_redir_aligned) begin
            // Flush: the held entry is dropped even if decode took it.
            r_pc    <= redirect_pc;
            r_valid <= 1'b0;
        end else if (w_redir_misaligned) begin
            r_pc          <= redirect_pc;
            r_valid       <= 1'b1;
            r_entry.pc    <= redirect_pc;
            r_entry.instr <= NOP_WORD;
            r_entry.fault <= 1'b1;
        end else if (w_capture) begin
            r_valid       <= 1'b1;
            r_entry.pc    <= r_pc;
            r_entry.instr <= idata;
            r_entry.fault <= 1'b0;
            // EBREAK parks the PC on itself; otherwise advance (wraps mod 2^32).
            if (!w_is_ebreak) begin
                r_pc <= r_pc + 32'd4;
            end
        end else if (r_valid && out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign iaddr     = r_pc;
    assign out_valid = r_valid;
    assign out_pc    = r_entry.pc;
    assign out_instr = r_entry.instr;
    assign out_fault = r_entry.fault;

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
// Directed bench for fetch_unit. A small word memory answers iaddr
// combinationally. Expected IF/ID entries are pushed to a queue as the
// stimulus is planned and popped whenever decode accepts an entry.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] iaddr;
    logic [31:0] idata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_fault;
    logic        halted;
    logic [1:0]  dbg_state;

    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] EBREAK = 32'h0010_0073;

    logic [31:0] mem [0:63];
    logic [64:0] exp_q [$];   // {pc, instr, fault}

    int checks;
    int failures;

    assign idata = mem[iaddr[7:2]];

    fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .iaddr          (iaddr),
        .idata          (idata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .out_fault      (out_fault),
        .halted         (halted),
        .dbg_state      (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] word_at(input logic [31:0] addr);
        return mem[addr[7:2]];
    endfunction

    task automatic push_exp(input logic [31:0] pc, input logic [31:0] instr, input logic fault);
        exp_q.push_back({pc, instr, fault});
    endtask

    // Scoreboard pop for a handshake happening on the coming edge, then
    // advance one clock and settle 1 time unit past the edge.
    task automatic cyc();
        logic [64:0] e;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_entry", out_pc, 32'hDEAD_BEEF);
            end else begin
                e = exp_q.pop_front();
                chk("sb_pc",    out_pc,              e[64:33]);
                chk("sb_instr", out_instr,           e[32:1]);
                chk("sb_fault", {31'h0, out_fault},  {31'h0, e[0]});
            end
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        checks   = 0;
        failures = 0;
        for (int i = 0; i < 64; i++) begin
            mem[i] = {i[11:0], 20'h00093} + 32'h0050_0000;
        end
        mem[0] = 32'h0050_0093;
        mem[1] = 32'h00A0_0113;
        mem[2] = 32'h00F0_0193;
        mem[3] = 32'h0140_0213;

        rst_n          = 1'b0;
        out_ready      = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_pc",    out_pc,             32'h0);
        chk("rst_instr", out_instr,          NOP);
        chk("rst_fault", {31'h0, out_fault}, 32'h0);
        chk("rst_halt",  {31'h0, halted},    32'h0);
        chk("rst_iaddr", iaddr,              32'h0);

        // ---- streaming ----
        rst_n = 1'b1;
        push_exp(32'h0, word_at(32'h0), 1'b0);
        push_exp(32'h4, word_at(32'h4), 1'b0);
        push_exp(32'h8, word_at(32'h8), 1'b0);
        cyc();                                    // BOOT edge
        chk("boot_valid", {31'h0, out_valid}, 32'h0);
        chk("boot_iaddr", iaddr, 32'h0);
        cyc();                                    // capture 0
        chk("first_valid", {31'h0, out_valid}, 32'h1);
        chk("first_iaddr", iaddr, 32'h4);
        cyc();                                    // pop 0, capture 4
        cyc();                                    // pop 4, capture 8

        // ---- stall ----
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("stall_valid", {31'h0, out_valid}, 32'h1);
            chk("stall_pc",    out_pc,    32'h8);
            chk("stall_instr", out_instr, word_at(32'h8));
            chk("stall_fault", {31'h0, out_fault}, 32'h0);
            chk("stall_iaddr", iaddr,     32'hC);
        end
        out_ready = 1'b1;
        push_exp(32'hC,  word_at(32'hC),  1'b0);
        push_exp(32'h10, word_at(32'h10), 1'b0);
        cyc();                                    // pop 8, capture C
        cyc();                                    // pop C, capture 10

        // ---- aligned redirect with simultaneous handshake ----
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        cyc();                                    // pop 10, flush
        redirect_valid = 1'b0;
        chk("redir_flush_valid", {31'h0, out_valid}, 32'h0);
        chk("redir_iaddr", iaddr, 32'h100);
        push_exp(32'h100, word_at(32'h100), 1'b0);
        cyc();                                    // capture 100
        chk("redir_target_valid", {31'h0, out_valid}, 32'h1);
        chk("redir_target_pc", out_pc, 32'h100);

        // ---- misaligned redirect ----
        redirect_valid = 1'b1;
        redirect_pc    = 32'h102;
        cyc();                                    // pop 100, fault entry
        redirect_valid = 1'b0;
        chk("mis_valid", {31'h0, out_valid}, 32'h1);
        chk("mis_fault", {31'h0, out_fault}, 32'h1);
        chk("mis_pc",    out_pc,    32'h102);
        chk("mis_instr", out_instr, NOP);
        chk("mis_halt",  {31'h0, halted}, 32'h1);
        chk("mis_iaddr", iaddr, 32'h102);
        push_exp(32'h102, NOP, 1'b1);
        cyc();                                    // pop fault entry
        for (int k = 0; k < 2; k++) begin
            cyc();
            chk("halt_no_capture", {31'h0, out_valid}, 32'h0);
            chk("halt_iaddr", iaddr, 32'h102);
            chk("halt_flag", {31'h0, halted}, 32'h1);
        end

        // ---- EBREAK halt ----
        mem[2] = EBREAK;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0;
        cyc();
        redirect_valid = 1'b0;
        chk("resume_halt", {31'h0, halted}, 32'h0);
        push_exp(32'h0, word_at(32'h0), 1'b0);
        push_exp(32'h4, word_at(32'h4), 1'b0);
        push_exp(32'h8, EBREAK, 1'b0);
        cyc();                                    // capture 0
        cyc();                                    // pop 0, capture 4
        cyc();                                    // pop 4, capture EBREAK
        chk("ebreak_halt",  {31'h0, halted}, 32'h1);
        chk("ebreak_iaddr", iaddr, 32'h8);
        cyc();                                    // pop EBREAK entry
        cyc();
        chk("ebreak_no_capture", {31'h0, out_valid}, 32'h0);
        chk("ebreak_iaddr_hold", iaddr, 32'h8);
        chk("ebreak_halt_hold", {31'h0, halted}, 32'h1);

        // ---- redirect to 0 resumes, then wrap ----
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0;
        cyc();
        redirect_valid = 1'b0;
        chk("resume2_halt", {31'h0, halted}, 32'h0);
        push_exp(32'h0, word_at(32'h0), 1'b0);
        cyc();                                    // capture 0
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        cyc();                                    // pop 0, flush
        redirect_valid = 1'b0;
        chk("wrap_flush_valid", {31'h0, out_valid}, 32'h0);
        push_exp(32'hFFFF_FFFC, word_at(32'hFFFF_FFFC), 1'b0);
        push_exp(32'h0, word_at(32'h0), 1'b0);
        cyc();                                    // capture FFFFFFFC
        chk("wrap_iaddr", iaddr, 32'h0);
        cyc();                                    // pop FFFFFFFC, capture 0
        cyc();                                    // pop 0, capture 4
        chk("post_wrap_pc", out_pc, 32'h4);

        // ---- asynchronous reset mid-operation ----
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", {31'h0, out_valid}, 32'h0);
        chk("async_rst_iaddr", iaddr, 32'h0);
        chk("async_rst_instr", out_instr, NOP);
        chk("async_rst_halt",  {31'h0, halted}, 32'h0);
        chk("sb_queue_empty", exp_q.size(), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the bench can never hang.
    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
